// File: rtl/compound_router.sv
// compound_router: buffered record router.
// Records {mode, x, y} enter a DEPTH-entry FIFO. A two-state dispatcher
// fetches the head record, presents it on the targeted output channel(s)
// and pops it once every target has taken it.
// Optional feature macro: COMPOUND_ROUTER_BCAST_EN. When defined, a record
// with y=1 goes to all channels. Otherwise y is only carried as data.

// One output channel: holds the presented record and its pending flag.
module compound_router_lane #(
  parameter int RW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] rec,
  input  logic          sync,
  output logic [RW-1:0] data,
  output logic          pend
);
  // Latch the record on fetch; drop pending the cycle after this channel transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      pend <= 1'b0;
    end else if (load) begin
      data <= rec;
      pend <= 1'b1;
    end else if (pend && sync) begin
      pend <= 1'b0;
    end
  end
endmodule

module compound_router #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           b_in_mode,
  input  logic [DATA_W-1:0]              b_in_x,
  input  logic                           b_in_y,
  input  logic                           b_in_sync,
  output logic                           b_in_notify,
  output logic [NUM_CH*(DATA_W+2)-1:0]   b_out_data,
  input  logic [NUM_CH-1:0]              b_out_sync,
  output logic [NUM_CH-1:0]              b_out_notify,
  output logic [$clog2(DEPTH):0]         fill_level
);
  localparam int RW = DATA_W + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_CH);

  typedef enum logic {SECTION_A, SECTION_B} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [RW-1:0]     head;
  logic [NUM_CH-1:0] mask, pending, remain;
  logic              accept, fetch, pop;

  // Full flag comes from the registered count only, so a same-cycle pop
  // never opens a slot for a new record.
  assign b_in_notify  = (count != (AW+1)'(DEPTH));
  assign accept       = b_in_sync && b_in_notify;
  assign fill_level   = count;
  assign head         = mem[rd_ptr];
  assign b_out_notify = pending;
  assign remain       = pending & ~b_out_sync;

  // Target selection: channel from the low x bits, optional broadcast on y.
  always_comb begin
    mask = '0;
    mask[head[CW:1]] = 1'b1;
`ifdef COMPOUND_ROUTER_BCAST_EN
    if (head[0]) mask = '1;
`endif
  end

  // Dispatcher next state: fetch when data is buffered, pop on the last transfer.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    pop       = 1'b0;
    case (state)
      SECTION_A: if (count != '0) begin
        fetch     = 1'b1;
        state_nxt = SECTION_B;
      end
      SECTION_B: if (remain == '0) begin
        pop       = 1'b1;
        state_nxt = SECTION_A;
      end
      default: state_nxt = SECTION_A;
    endcase
  end

  // Dispatcher state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SECTION_A;
    else     state <= state_nxt;
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {b_in_mode, b_in_x, b_in_y};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    compound_router_lane #(.RW(RW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (fetch && mask[c]),
      .rec  (head),
      .sync (b_out_sync[c]),
      .data (b_out_data[c*RW +: RW]),
      .pend (pending[c])
    );
  end
endmodule

// File: tb/tb_compound_router.sv
// Bench for compound_router: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_compound_router;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int RW     = DATA_W + 2;
  localparam int CW     = $clog2(NUM_CH);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     b_in_mode = 1'b0;
  logic [DATA_W-1:0]        b_in_x = '0;
  logic                     b_in_y = 1'b0;
  logic                     b_in_sync = 1'b0;
  logic                     b_in_notify;
  logic [NUM_CH*RW-1:0]     b_out_data;
  logic [NUM_CH-1:0]        b_out_sync = '0;
  logic [NUM_CH-1:0]        b_out_notify;
  logic [$clog2(DEPTH):0]   fill_level;

  compound_router #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in_mode    (b_in_mode),
    .b_in_x       (b_in_x),
    .b_in_y       (b_in_y),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .b_out_data   (b_out_data),
    .b_out_sync   (b_out_sync),
    .b_out_notify (b_out_notify),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of buffered records, a busy flag for the record
  // being delivered, the set of channels still owed it, and per-channel data.
  logic [RW-1:0]     m_q[$];
  logic [RW-1:0]     m_data[NUM_CH];
  logic [NUM_CH-1:0] m_pend;
  bit                m_busy;
  logic [DATA_W-1:0] seen[$];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = '0;
    m_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_data[c] = '0;
  endtask

  task automatic compare_model();
    logic [NUM_CH*RW-1:0] ed;
    for (int c = 0; c < NUM_CH; c++) ed[c*RW +: RW] = m_data[c];
    chk("in_notify", b_in_notify, (m_q.size() != DEPTH));
    chk("fill_level", fill_level, m_q.size());
    chk("out_notify", b_out_notify, m_pend);
    chk("out_data", b_out_data, ed);
  endtask

  // One clock: inputs are already set; advance the model at the edge and
  // compare on the following falling edge.
  task automatic cycle();
    logic [RW-1:0] rec;
    logic [RW-1:0] h;
    bit acc;
    int ch;
    rec = {b_in_mode, b_in_x, b_in_y};
    @(posedge clk);
    acc = b_in_sync && (m_q.size() < DEPTH);
    if (m_busy) begin
      for (int c = 0; c < NUM_CH; c++)
        if (m_pend[c] && b_out_sync[c]) begin
          seen.push_back(m_data[c][RW-2:1]);
          m_pend[c] = 1'b0;
        end
      if (m_pend == '0) begin
        void'(m_q.pop_front());
        m_busy = 1'b0;
      end
    end else if (m_q.size() > 0) begin
      h  = m_q[0];
      ch = int'(h[RW-2:1] % NUM_CH);
      for (int c = 0; c < NUM_CH; c++) begin
        bit tgt;
        tgt = (c == ch);
`ifdef COMPOUND_ROUTER_BCAST_EN
        if (h[0]) tgt = 1'b1;
`endif
        if (tgt) begin
          m_data[c] = h;
          m_pend[c] = 1'b1;
        end
      end
      m_busy = 1'b1;
    end
    if (acc) m_q.push_back(rec);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit                in_sync;
    bit [DATA_W-1:0]   x;
    bit [NUM_CH-1:0]   out_sync;
    bit                exp_in_not;
    int                exp_fill;
    bit [NUM_CH-1:0]   exp_onot;
  } vec_t;

  vec_t tbl[$];
  logic [DATA_W-1:0] exp_order[$];

  initial begin
    // Single record to channel 1, all consumers ready.
    tbl.push_back('{1, 5, 2'b11, 1, 1, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 1, 1, 2'b10});
    tbl.push_back('{0, 0, 2'b11, 1, 0, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 1, 0, 2'b00});
    // Fill with consumers stalled; fifth offer rejected.
    tbl.push_back('{1, 0, 2'b00, 1, 1, 2'b00});
    tbl.push_back('{1, 1, 2'b00, 1, 2, 2'b01});
    tbl.push_back('{1, 2, 2'b00, 1, 3, 2'b01});
    tbl.push_back('{1, 3, 2'b00, 0, 4, 2'b01});
    tbl.push_back('{1, 4, 2'b00, 0, 4, 2'b01});
    // Full: offer alongside a pop is refused, then accepted next cycle.
    tbl.push_back('{1, 4, 2'b01, 1, 3, 2'b00});
    tbl.push_back('{1, 4, 2'b00, 0, 4, 2'b10});

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_notify", b_in_notify, 1'b1);
    chk("reset_fill", fill_level, 0);
    chk("reset_out_notify", b_out_notify, 0);
    chk("reset_out_data", b_out_data, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 4) seen.delete();
      b_in_sync  = tbl[i].in_sync;
      b_in_mode  = 1'b1;
      b_in_x     = tbl[i].x;
      b_in_y     = 1'b0;
      b_out_sync = tbl[i].out_sync;
      cycle();
      chk($sformatf("vec%0d_in_notify", i), b_in_notify, tbl[i].exp_in_not);
      chk($sformatf("vec%0d_fill", i), fill_level, tbl[i].exp_fill);
      chk($sformatf("vec%0d_out_notify", i), b_out_notify, tbl[i].exp_onot);
      if (i == 1) chk("vec1_ch1_data", b_out_data[RW +: RW], {1'b1, 32'd5, 1'b0});
    end

    // Drain and confirm records left in arrival order.
    b_in_sync  = 1'b0;
    b_out_sync = 2'b11;
    repeat (12) cycle();
    exp_order = '{0, 1, 2, 3, 4};
    chk("drain_count", seen.size(), exp_order.size());
    for (int i = 0; i < seen.size() && i < exp_order.size(); i++)
      chk($sformatf("drain_order%0d", i), seen[i], exp_order[i]);
    chk("drain_fill", fill_level, 0);

    // Reset while delivering with three records buffered.
    b_out_sync = 2'b00;
    b_in_sync  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_x = 32'(10 + i);
      cycle();
    end
    b_in_sync = 1'b0;
    chk("pre_rst_fill", fill_level, 3);
    chk("pre_rst_out_notify", b_out_notify, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_notify", b_out_notify, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_in_notify", b_in_notify, 1'b1);
    chk("rst_out_data", b_out_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    seen.delete();
    b_out_sync = 2'b11;
    repeat (5) cycle();
    chk("post_rst_transfers", seen.size(), 0);
    chk("post_rst_out_notify", b_out_notify, 0);

`ifdef COMPOUND_ROUTER_BCAST_EN
    // Broadcast: both rise together; channels finish independently.
    b_out_sync = 2'b00;
    b_in_sync = 1'b1; b_in_x = 32'd6; b_in_y = 1'b1;
    cycle();
    b_in_sync = 1'b0; b_in_y = 1'b0;
    cycle();
    chk("bcast_rise", b_out_notify, 2'b11);
    b_out_sync = 2'b01;
    cycle();
    chk("bcast_ch0_drop", b_out_notify, 2'b10);
    b_out_sync = 2'b00;
    repeat (2) cycle();
    chk("bcast_hold_fill", fill_level, 1);
    b_out_sync = 2'b10;
    cycle();
    chk("bcast_pop_fill", fill_level, 0);
    chk("bcast_done", b_out_notify, 2'b00);
`else
    // Without broadcast, y=1 is data only: x=2 goes to channel 0.
    b_out_sync = 2'b00;
    b_in_sync = 1'b1; b_in_mode = 1'b0; b_in_x = 32'd2; b_in_y = 1'b1;
    cycle();
    b_in_sync = 1'b0; b_in_y = 1'b0;
    cycle();
    chk("ucast_y_notify", b_out_notify, 2'b01);
    chk("ucast_y_data", b_out_data[0 +: RW], {1'b0, 32'd2, 1'b1});
    b_out_sync = 2'b01;
    cycle();
    chk("ucast_y_done", b_out_notify, 2'b00);
    chk("ucast_y_fill", fill_level, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      b_in_sync  = ($urandom_range(0, 3) != 0);
      b_in_mode  = 1'($urandom);
      b_in_x     = $urandom;
      b_in_y     = 1'($urandom);
      b_out_sync = NUM_CH'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
